// File: rtl/bht_update_scheduler_if.sv
// IF-stage lookup and ID-stage resolved-branch update channel of the BHT scheduler.
// The master drives lookups and updates; the slave returns the prediction and queue readiness.
interface bht_update_scheduler_if #(
  parameter int IDX_W = 5
);
  logic [IDX_W-1:0] lookup_idx_IF;
  logic             pred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;

  modport master (
    output lookup_idx_IF, upd_valid, upd_idx, upd_taken,
    input  pred_taken, upd_ready
  );

  modport slave (
    input  lookup_idx_IF, upd_valid, upd_idx, upd_taken,
    output pred_taken, upd_ready
  );
endinterface

// File: rtl/bht_update_scheduler.sv
// 2-bit BHT with init/clear walker and resolved-update queue; combinational lookup, update visible one edge after acceptance.
// upd_ready = RUN and queue not full; refused updates are counted in drop_cnt; drains are held while the hazard stall is high.
module bht_upd_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer MSB tells full from empty when the address bits match.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module bht_update_scheduler #(
  parameter int         IDX_W      = 5,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] CNT_INIT   = 2'b01,
  parameter int         DROP_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bht_update_scheduler_if.slave bus,
  input  logic                  brch_hazard_stall,
  input  logic                  clr_req,
  output logic                  busy,
  output logic [DROP_W-1:0]     drop_cnt
);
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_t;

  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_idx, init_idx_nxt;
  logic             init_wr;
  logic [1:0]       bht [2**IDX_W];

  logic upd_ready;
  logic q_push, q_pop, q_flush, q_full, q_empty;
  upd_t push_dat, head;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    busy         = 1'b0;
    init_wr      = 1'b0;
    unique case (state)
      ST_INIT: begin
        busy    = 1'b1;
        init_wr = 1'b1;
        if (clr_req) begin
          init_idx_nxt = '0;
        end else if (init_idx == IDX_LAST) begin
          state_nxt    = ST_RUN;
          init_idx_nxt = '0;
        end else begin
          init_idx_nxt = init_idx + IDX_W'(1);
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_nxt    = ST_INIT;
          init_idx_nxt = '0;
        end
      end
    endcase
  end

  assign upd_ready     = (state == ST_RUN) && !q_full;
  assign bus.upd_ready = upd_ready;
  assign q_push        = bus.upd_valid && upd_ready;
  // A clear in the same cycle wins over a drain: the walk rewrites the table anyway.
  assign q_pop         = (state == ST_RUN) && !q_empty && !brch_hazard_stall && !clr_req;
  assign q_flush       = clr_req || (state == ST_INIT);
  assign push_dat      = {bus.upd_idx, bus.upd_taken};

  bht_upd_fifo #(
    .W     ($bits(upd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_upd_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (q_flush),
    .push     (q_push),
    .push_dat (push_dat),
    .pop      (q_pop),
    .pop_dat  (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Table has no reset; the walk after reset defines every entry.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (init_wr) begin
        bht[init_idx] <= CNT_INIT;
      end else if (q_pop) begin
        bht[head.idx] <= head.taken ? sat_inc(bht[head.idx]) : sat_dec(bht[head.idx]);
      end
    end
  end

  assign bus.pred_taken = (state == ST_RUN) ? bht[bus.lookup_idx_IF][1] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (bus.upd_valid && !upd_ready && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end
endmodule

// File: tb/tb_bht_update_scheduler.sv
// Directed bench for bht_update_scheduler: init walk, counter training, stall/full, same-index burst, clear, reset mid-walk.
module tb_bht_update_scheduler;
  localparam int IDX_W = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       clr = 1'b0;
  logic       busy;
  logic [7:0] drop_cnt;
  int         checks = 0;
  int         errors = 0;
  int         n;

  always #5 clk = ~clk;

  bht_update_scheduler_if #(.IDX_W(IDX_W)) bus ();

  bht_update_scheduler #(
    .IDX_W      (IDX_W),
    .FIFO_DEPTH (4),
    .CNT_INIT   (2'b01),
    .DROP_W     (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .brch_hazard_stall (stall),
    .clr_req           (clr),
    .busy              (busy),
    .drop_cnt          (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pred_chk(input string tag, input int idx, input logic exp);
    bus.lookup_idx_IF = IDX_W'(idx);
    #1;
    chk(tag, 32'(bus.pred_taken), 32'(exp));
  endtask

  // One update accepted on the first edge and written on the second.
  task automatic single(input int idx, input logic taken);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = IDX_W'(idx);
    bus.upd_taken = taken;
    tick();
    bus.upd_valid = 1'b0;
    tick();
  endtask

  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lookup_idx_IF = '0;
    bus.upd_valid     = 1'b0;
    bus.upd_idx       = '0;
    bus.upd_taken     = 1'b0;
    tick();
    tick();
    chk("rst_busy",  32'(busy), 1);
    chk("rst_ready", 32'(bus.upd_ready), 0);
    chk("rst_pred",  32'(bus.pred_taken), 0);
    chk("rst_drop",  32'(drop_cnt), 0);

    // T1: 32-cycle walk; two updates offered during it are dropped
    rst_n         = 1'b1;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 5'd1;
    bus.upd_taken = 1'b1;
    #1;
    chk("init_ready", 32'(bus.upd_ready), 0);
    n = 0;
    while (busy && n < 100) begin
      if (n == 2) bus.upd_valid = 1'b0;
      tick();
      n++;
    end
    chk("init_len",   32'(n), 32);
    chk("init_drops", 32'(drop_cnt), 2);
    chk("run_ready",  32'(bus.upd_ready), 1);
    for (int i = 0; i < 32; i++) begin
      pred_chk("init_pred", i, 1'b0);
      tick();
    end

    // T2: latency and saturation on idx 3
    bus.lookup_idx_IF = 5'd3;
    bus.upd_valid     = 1'b1;
    bus.upd_idx       = 5'd3;
    bus.upd_taken     = 1'b1;
    tick();
    bus.upd_valid = 1'b0;
    pred_chk("t2_lat_pre", 3, 1'b0);
    tick();
    pred_chk("t2_lat_post", 3, 1'b1);
    single(3, 1'b1);
    single(3, 1'b1);
    single(3, 1'b0);
    pred_chk("t2_sat_hi", 3, 1'b1);
    single(3, 1'b0);
    single(3, 1'b0);
    single(3, 1'b0);
    single(3, 1'b0);
    pred_chk("t2_sat_lo", 3, 1'b0);
    single(3, 1'b1);
    pred_chk("t2_up1", 3, 1'b0);
    single(3, 1'b1);
    pred_chk("t2_up2", 3, 1'b1);
    pred_chk("t2_neighbour", 4, 1'b0);

    // T3: fill under stall, drop one, then drain in order one per edge
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.upd_valid = 1'b1;
      bus.upd_idx   = IDX_W'(8 + k);
      bus.upd_taken = 1'b1;
      #1;
      chk("t3_ready", 32'(bus.upd_ready), 1);
      tick();
    end
    bus.upd_idx = 5'd12;
    #1;
    chk("t3_full", 32'(bus.upd_ready), 0);
    tick();
    bus.upd_valid = 1'b0;
    chk("t3_drop", 32'(drop_cnt), 3);
    pred_chk("t3_stalled", 8, 1'b0);
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      pred_chk("t3_drain", 8 + k, 1'b1);
      if (k < 3) pred_chk("t3_order", 9 + k, 1'b0);
      if (k == 0) chk("t3_ready_again", 32'(bus.upd_ready), 1);
    end
    pred_chk("t3_dropped", 12, 1'b0);
    chk("t3_drop_hold", 32'(drop_cnt), 3);

    // T4: six back-to-back taken updates to idx 7 from 00
    single(7, 1'b0);
    single(7, 1'b0);
    pred_chk("t4_base", 7, 1'b0);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 5'd7;
    bus.upd_taken = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t4_ready", 32'(bus.upd_ready), 1);
      tick();
    end
    bus.upd_valid = 1'b0;
    tick();
    pred_chk("t4_hi", 7, 1'b1);
    single(7, 1'b0);
    pred_chk("t4_was_sat", 7, 1'b1);
    single(7, 1'b0);
    pred_chk("t4_dec2", 7, 1'b0);
    chk("t4_nodrop", 32'(drop_cnt), 3);

    // T5: clear with two updates pending
    stall = 1'b1;
    bus.upd_valid = 1'b1;
    bus.upd_taken = 1'b1;
    bus.upd_idx   = 5'd8;
    tick();
    bus.upd_idx   = 5'd9;
    tick();
    bus.upd_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr   = 1'b0;
    stall = 1'b0;
    chk("t5_busy",  32'(busy), 1);
    chk("t5_ready", 32'(bus.upd_ready), 0);
    count_busy(n);
    chk("t5_len", 32'(n), 32);
    for (int i = 0; i < 32; i++) begin
      pred_chk("t5_pred", i, 1'b0);
      tick();
    end
    chk("t5_drop", 32'(drop_cnt), 3);

    // T6: reset ten entries into a clear walk
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("t6_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_busy",  32'(busy), 1);
    chk("t6_drop",  32'(drop_cnt), 0);
    chk("t6_ready", 32'(bus.upd_ready), 0);
    count_busy(n);
    chk("t6_len", 32'(n), 32);
    chk("t6_drop_end", 32'(drop_cnt), 0);
    pred_chk("t6_pred", 31, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
